// File: rtl/am_vector_store_pkg.sv
// Shared AM package: geometry, row/column types and the write FSM encoding.
// Imported by the vector store, its row bank and the write interface.
package am_vector_store_pkg;

  localparam int unsigned VECTOR_CNT      = 4;
  localparam int unsigned ROWS_PER_HDVECT = 2;
  localparam int unsigned MEM_ROW_WIDTH   = 8;
  localparam int unsigned ROW_CNT         = VECTOR_CNT * ROWS_PER_HDVECT;

  localparam int unsigned VECTOR_IDX_W  = 3;
  localparam int unsigned COLUMN_ADDR_W = 4;

  localparam int unsigned BEAT_W =
    (ROWS_PER_HDVECT > 1) ? $clog2(ROWS_PER_HDVECT) : 1;
  localparam int unsigned COL_SEL_W =
    (MEM_ROW_WIDTH > 1) ? $clog2(MEM_ROW_WIDTH) : 1;
  // wide enough for any index value times rows per vector
  localparam int unsigned ROW_ADDR_W =
    $clog2((2 ** VECTOR_IDX_W) * ROWS_PER_HDVECT);

  typedef logic [MEM_ROW_WIDTH-1:0] row_t;
  typedef logic [ROW_CNT-1:0]       column_t;
  typedef logic [COLUMN_ADDR_W-1:0] column_addr_t;
  typedef logic [VECTOR_IDX_W-1:0]  vector_idx_t;
  typedef logic [BEAT_W-1:0]        beat_t;
  typedef logic [ROW_ADDR_W-1:0]    row_addr_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DONE = 2'd2
  } wr_state_e;

  localparam beat_t BEAT_LAST = beat_t'(ROWS_PER_HDVECT - 1);

  function automatic logic idx_in_range(vector_idx_t idx);
    return int'(idx) < int'(VECTOR_CNT);
  endfunction

  function automatic row_addr_t row_addr(vector_idx_t idx, beat_t beat);
    return row_addr_t'(row_addr_t'(idx) * row_addr_t'(ROWS_PER_HDVECT)
                       + row_addr_t'(beat));
  endfunction

endpackage

// File: rtl/am_vector_store_if.sv
// Beat-wise vector write channel into the AM vector store.
// master = writer, slave = store.
interface am_vector_store_if;
  import am_vector_store_pkg::*;

  logic        wr_valid_i;
  logic        wr_ready_o;
  vector_idx_t wr_vector_idx_i;
  row_t        wr_row_i;
  logic        wr_done_o;
  logic        wr_err_o;

  modport master (
    output wr_valid_i,
    output wr_vector_idx_i,
    output wr_row_i,
    input  wr_ready_o,
    input  wr_done_o,
    input  wr_err_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_vector_idx_i,
    input  wr_row_i,
    output wr_ready_o,
    output wr_done_o,
    output wr_err_o
  );

endinterface

// File: rtl/am_vector_store_row_bank.sv
// Flop row array with a single row write port and a
// combinational column read (pre-write data in the write cycle).
module am_row_bank
  import am_vector_store_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  row_addr_t    waddr_i,
  input  row_t         wdata_i,
  input  column_addr_t column_addr_i,
  output column_t      column_o
);

  row_t mem_q [ROW_CNT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < ROW_CNT; r++) begin
        mem_q[r] <= '0;
      end
    end else if (we_i) begin
      for (int r = 0; r < ROW_CNT; r++) begin
        if (waddr_i == row_addr_t'(r)) begin
          mem_q[r] <= wdata_i;
        end
      end
    end
  end

  logic [COL_SEL_W-1:0] col_sel;
  logic                 col_ok;

  assign col_sel = column_addr_i[COL_SEL_W-1:0];
  assign col_ok  = int'(column_addr_i) < int'(MEM_ROW_WIDTH);

  always_comb begin
    column_o = '0;
    if (col_ok) begin
      for (int r = 0; r < ROW_CNT; r++) begin
        column_o[r] = mem_q[r][col_sel];
      end
    end
  end

endmodule

// File: rtl/am_vector_store.sv
// AM vector store: beat-wise vector writes into a row bank,
// column-wise reads for the search unit.
module am_vector_store
  import am_vector_store_pkg::*;
#(
  parameter bit WRITE_LOCK_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  am_vector_store_if.slave wr,
  input  logic             search_busy_i,
  input  column_addr_t     column_addr_i,
  output column_t          column_o
);

  wr_state_e   state_q, state_d;
  beat_t       beat_q, beat_d;
  vector_idx_t idx_q, idx_d;

  logic      lock;
  logic      ready;
  logic      done;
  logic      err;
  logic      row_we;
  row_addr_t row_waddr;

  assign lock = WRITE_LOCK_EN & search_busy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WR_IDLE;
      beat_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    ready     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    row_we    = 1'b0;
    row_waddr = row_addr(idx_q, beat_q);
    unique case (state_q)
      WR_IDLE: begin
        ready = !lock;
        if (wr.wr_valid_i && !lock) begin
          idx_d     = wr.wr_vector_idx_i;
          row_waddr = row_addr(wr.wr_vector_idx_i, '0);
          row_we    = idx_in_range(wr.wr_vector_idx_i);
          beat_d    = beat_t'(1);
          state_d   = (ROWS_PER_HDVECT == 1) ? WR_DONE : WR_FILL;
        end
      end
      WR_FILL: begin
        ready = !lock;
        if (wr.wr_valid_i && !lock) begin
          row_we = idx_in_range(idx_q);
          beat_d = beat_t'(beat_q + 1'b1);
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = WR_DONE;
          end
        end
      end
      WR_DONE: begin
        done    = 1'b1;
        err     = !idx_in_range(idx_q);
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  assign wr.wr_ready_o = ready;
  assign wr.wr_done_o  = done;
  assign wr.wr_err_o   = err;

  am_row_bank u_bank (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .we_i          (row_we),
    .waddr_i       (row_waddr),
    .wdata_i       (wr.wr_row_i),
    .column_addr_i (column_addr_i),
    .column_o      (column_o)
  );

endmodule

// File: doc/am_vector_store.md
AM_VECTOR_STORE -- requirements
Module: am_vector_store

Interface
REQ-001 SHALL have parameter: WRITE_LOCK_EN, 1, when 1 search_busy_i blocks writes; when 0 it is ignored.
REQ-002 SHALL have port: clk_i  in  1  clock.
REQ-003 SHALL have port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: wr_valid_i  in  1  write beat valid.
REQ-005 SHALL have port: wr_ready_o  out  1  write beat accepted when both valid and ready are high.
REQ-006 SHALL have port: wr_vector_idx_i  in  vector_idx_t  target vector, sampled on the first beat only.
REQ-007 SHALL have port: wr_row_i  in  MEM_ROW_WIDTH  row data for the current beat.
REQ-008 SHALL have port: wr_done_o  out  1  one-cycle pulse after the last beat of a vector.
REQ-009 SHALL have port: wr_err_o  out  1  one-cycle pulse with wr_done_o when the latched index is >= VECTOR_CNT.
REQ-010 SHALL have port: search_busy_i  in  1  search unit is scanning columns.
REQ-011 SHALL have port: column_addr_i  in  column_addr_t  column select from the search unit.
REQ-012 SHALL have port: column_o  out  column_t  bit r = mem[r][column_addr_i].

Function
REQ-013 Storage SHALL be ROW_CNT rows x MEM_ROW_WIDTH bits, flop-based; vector v occupies rows v*ROWS_PER_HDVECT .. v*ROWS_PER_HDVECT+ROWS_PER_HDVECT-1.
REQ-014 The read port SHALL be combinational, with zero-cycle latency from column_addr_i to column_o.
REQ-015 column_addr_i >= MEM_ROW_WIDTH SHALL give column_o = 0.
REQ-016 A read and a write in the same cycle SHALL return the pre-write contents; the write is visible from the next cycle.
REQ-017 The FSM SHALL have states Idle, Fill, Done; any illegal encoding goes to Idle.
REQ-018 Idle: wr_ready_o = !lock, where lock = WRITE_LOCK_EN & search_busy_i.
REQ-019 Idle, on accept: latch the index, write beat 0 to the base row, set beat_cnt = 1, then go to Fill (or to Done if ROWS_PER_HDVECT == 1).
REQ-020 Fill: wr_ready_o = !lock; each accept writes row base+beat_cnt and increments beat_cnt.
REQ-021 Fill: the accept with beat_cnt == ROWS_PER_HDVECT-1 SHALL go to Done.
REQ-022 Fill: wr_vector_idx_i SHALL be ignored.
REQ-023 Done: wr_done_o = 1 and wr_ready_o = 0 for exactly one cycle, then go to Idle.
REQ-024 lock asserted mid-vector SHALL hold the FSM in Fill with beat_cnt unchanged, perform no row writes, and keep wr_ready_o = 0.
REQ-025 An out-of-range latched index SHALL still accept all ROWS_PER_HDVECT beats, write no rows, and assert wr_err_o together with wr_done_o.
REQ-026 wr_valid_i low SHALL never change state or memory.
REQ-027 Once wr_valid_i is high and wr_ready_o is low, wr_valid_i and wr_row_i SHALL be held stable by the writer (assertion in bench).
REQ-028 beat_cnt SHALL be $clog2(ROWS_PER_HDVECT) bits wide, minimum 1 bit.
REQ-029 Row address computation SHALL be performed at a width that cannot overflow for VECTOR_CNT*ROWS_PER_HDVECT.

Reset
REQ-030 Reset SHALL set the state to Idle, beat_cnt and the latched index to 0, and all memory bits to 0.
REQ-031 Output reset values SHALL be: wr_ready_o = !lock (combinational), wr_done_o = 0, wr_err_o = 0, column_o = 0.
REQ-032 Reset mid-Fill SHALL abandon the vector; all rows read 0 afterwards.

Structure
REQ-033 ROW_CNT, ROWS_PER_HDVECT, MEM_ROW_WIDTH, VECTOR_CNT, column_t, column_addr_t and vector_idx_t SHALL come from the shared AM package; a new row_t (MEM_ROW_WIDTH bits) SHALL be added there.
REQ-034 The block SHALL contain one sub-module, am_row_bank: the flop array with row write-enable and the column mux, with no control logic.

Verification
REQ-035 Scenario 1: with ROWS_PER_HDVECT=2, MEM_ROW_WIDTH=8, VECTOR_CNT=4, write idx 1 with rows 0xA5, 0x0F -> rows 2 and 3 hold those values; column 0 gives bit2=1, bit3=1; column 4 gives bit2=0, bit3=0; wr_done_o pulses 1 cycle after the 2nd accept.
REQ-036 Scenario 2: assert search_busy_i after beat 0 for 5 cycles -> wr_ready_o=0 for those 5 cycles, row 1 of the vector is unchanged, and the write completes after release.
REQ-037 Scenario 3: write idx 5 (>= VECTOR_CNT) -> 2 beats accepted, wr_done_o and wr_err_o pulse together, all memory unchanged.
REQ-038 Scenario 4: column_addr_i=3 while a write to row 0 bit 3 occurs in the same cycle -> old bit seen that cycle, new bit seen the next cycle; column_addr_i=9 -> column_o=0.
REQ-039 Scenario 5: assert rst_ni low after beat 0 of idx 0 -> state returns to Idle, all rows 0, and the next write starts cleanly at beat 0.
REQ-040 Scenario 6: back-to-back vectors idx 0 then idx 3 with wr_valid_i held high -> exactly one Done cycle between them, both vectors stored correctly.
